key_conditioner: RTL and testbench



---
 rtl/key_conditioner_if.sv | 18 +
 rtl/key_conditioner.sv | 98 +++++++++
 tb/tb_key_conditioner.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: raw key levels in, conditioned adjust/clear/keep controls out
interface key_conditioner_if;
  logic [4:0] key_raw;
  logic       adjust_sec;
  logic       adjust_min;
  logic       adjust_hour;
  logic       clear_pulse;
  logic       keep;
  logic [4:0] key_level;
  modport master (
    output key_raw,
    input  adjust_sec, adjust_min, adjust_hour, clear_pulse, keep, key_level
  );
  modport slave (
    input  key_raw,
    output adjust_sec, adjust_min, adjust_hour, clear_pulse, keep, key_level
  );
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner: debounces raw push-buttons into adjust pulses with auto-repeat, a clear pulse and a keep toggle
module key_conditioner #(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input logic clk_1000hz,
  input logic clear,
  key_conditioner_if.slave kif
);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [4:0] RELEASED = {5{ACTIVE_LOW}};
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;
  logic [4:0]    sync1, sync2, pressed, level, level_d, rise;
  logic [DW-1:0] db_cnt [5];
  rpt_state_t    state [3];
  rpt_state_t    state_next [3];
  logic [RW-1:0] rpt_cnt [3];
  logic [RW-1:0] rpt_cnt_next [3];
  logic [2:0]    fire, adjust;
  logic          clear_q, keep_q;
  assign pressed = sync2 ^ RELEASED;
  assign rise = level & ~level_d;
  // two-flop synchronizer plus delayed level for rising-edge detection
  always_ff @(posedge clk_1000hz)
    if (clear) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
      level_d <= '0;
    end else begin
      sync1 <= kif.key_raw;
      sync2 <= sync1;
      level_d <= level;
    end
  // debounce: flip a key level once the synced input has disagreed with it for DEBOUNCE_TICKS+1 samples
  always_ff @(posedge clk_1000hz)
    for (int i = 0; i < 5; i++)
      if (clear) begin
        db_cnt[i] <= '0;
        level[i] <= 1'b0;
      end else if (pressed[i] == level[i]) begin
        db_cnt[i] <= '0;
      end else if (db_cnt[i] == DW'(DEBOUNCE_TICKS)) begin
        db_cnt[i] <= '0;
        level[i] <= ~level[i];
      end else begin
        db_cnt[i] <= db_cnt[i] + 1'b1;
      end
  // auto-repeat state and tick counter per adjust key
  always_ff @(posedge clk_1000hz)
    for (int i = 0; i < 3; i++)
      if (clear) begin
        state[i] <= IDLE;
        rpt_cnt[i] <= '0;
      end else begin
        state[i] <= state_next[i];
        rpt_cnt[i] <= rpt_cnt_next[i];
      end
  // auto-repeat next state: pulse on press, after the delay, then at the repeat rate; release cancels
  always_comb
    for (int i = 0; i < 3; i++) begin
      state_next[i] = state[i];
      rpt_cnt_next[i] = rpt_cnt[i] + 1'b1;
      fire[i] = 1'b0;
      if (state[i] == IDLE) begin
        rpt_cnt_next[i] = '0;
        fire[i] = rise[i];
        state_next[i] = rise[i] ? DELAY : IDLE;
      end else if (!level[i]) begin
        rpt_cnt_next[i] = '0;
        state_next[i] = IDLE;
      end else if (rpt_cnt[i] == (state[i] == DELAY ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1))) begin
        rpt_cnt_next[i] = '0;
        fire[i] = 1'b1;
        state_next[i] = REPEAT;
      end
    end
  // registered outputs so nothing reaches the pins combinationally
  always_ff @(posedge clk_1000hz)
    if (clear) begin
      adjust <= '0;
      clear_q <= 1'b0;
      keep_q <= 1'b0;
    end else begin
      adjust <= fire;
      clear_q <= rise[3];
      keep_q <= keep_q ^ rise[4];
    end
  assign kif.adjust_sec = adjust[0];
  assign kif.adjust_min = adjust[1];
  assign kif.adjust_hour = adjust[2];
  assign kif.clear_pulse = clear_q;
  assign kif.keep = keep_q;
  assign kif.key_level = level;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: table, directed and random checks against a sample-window reference model
module tb_key_conditioner;
  localparam int D = 20;
  localparam int RD = 500;
  localparam int RR = 100;
  localparam int MAXC = 30000;
  localparam logic [4:0] REL = 5'b11111;
  logic clk = 1'b0;
  logic clear = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 1;
  logic [4:0] hist [MAXC];
  logic [4:0] lev [MAXC];
  int ls [3];
  logic keep_m;
  key_conditioner_if kif();
  key_conditioner #(
    .DEBOUNCE_TICKS(D),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_1000hz(clk),
    .clear(clear),
    .kif(kif)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] raw;
    int ticks;
    int n_sec;
    int n_min;
    int n_hour;
    int n_clr;
    logic [4:0] lvl;
    logic keep;
  } vec_t;
  vec_t tbl [11];
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask
  function automatic int outs();
    return int'({kif.adjust_hour, kif.adjust_min, kif.adjust_sec, kif.clear_pulse, kif.keep, kif.key_level});
  endfunction
  // one clock edge: advance the model from the sampled inputs, then compare every output
  task automatic step();
    logic [4:0] pr, rise;
    logic [2:0] ea;
    logic ec;
    bit flip;
    int t, d;
    @(posedge clk);
    if (cyc >= MAXC - 1) begin
      $display("FAIL model_overflow got %0d want <%0d", cyc, MAXC - 1);
      $fatal(1);
    end
    cyc++;
    t = cyc;
    pr = kif.key_raw ^ REL;
    ea = '0;
    ec = 1'b0;
    if (clear) begin
      hist[t] = '0;
      hist[t-1] = '0;
      lev[t] = '0;
      keep_m = 1'b0;
    end else begin
      hist[t] = pr;
      rise = lev[t-1] & ~lev[t-2];
      for (int k = 0; k < 5; k++) begin
        lev[t][k] = lev[t-1][k];
        if (t - 2 - D >= 0) begin
          flip = 1'b1;
          for (int j = t - 2 - D; j <= t - 2; j++)
            if (hist[j][k] == lev[t-1][k]) flip = 1'b0;
          if (flip) lev[t][k] = ~lev[t-1][k];
        end
      end
      ec = rise[3];
      keep_m = keep_m ^ rise[4];
      for (int k = 0; k < 3; k++) begin
        if (rise[k]) ls[k] = t - 1;
        d = t - 1 - ls[k];
        ea[k] = lev[t-1][k] && (d == 0 || (d >= RD && (d - RD) % RR == 0));
      end
    end
    #1;
    check("model", outs(), int'({ea, ec, keep_m, lev[t]}));
  endtask
  task automatic run(input logic [4:0] raw, input int n, output int cs, output int cm, output int ch, output int cc);
    kif.key_raw = raw;
    cs = 0;
    cm = 0;
    ch = 0;
    cc = 0;
    repeat (n) begin
      step();
      cs += int'(kif.adjust_sec);
      cm += int'(kif.adjust_min);
      ch += int'(kif.adjust_hour);
      cc += int'(kif.clear_pulse);
    end
  endtask
  initial begin
    int cs, cm, ch, cc, n, hold, seen;
    for (int i = 0; i < MAXC; i++) begin
      hist[i] = '0;
      lev[i] = '0;
    end
    for (int k = 0; k < 3; k++) ls[k] = 0;
    keep_m = 1'b0;
    kif.key_raw = REL;
    tbl[0]  = '{5'b11111,   50, 0, 0, 0, 0, 5'b00000, 1'b0};
    tbl[1]  = '{5'b11101, 1000, 0, 6, 0, 0, 5'b00010, 1'b0};
    tbl[2]  = '{5'b11111,  100, 0, 0, 0, 0, 5'b00000, 1'b0};
    tbl[3]  = '{5'b01111,   50, 0, 0, 0, 0, 5'b10000, 1'b1};
    tbl[4]  = '{5'b11111,   50, 0, 0, 0, 0, 5'b00000, 1'b1};
    tbl[5]  = '{5'b01111,   50, 0, 0, 0, 0, 5'b10000, 1'b0};
    tbl[6]  = '{5'b11111,   50, 0, 0, 0, 0, 5'b00000, 1'b0};
    tbl[7]  = '{5'b10111, 1000, 0, 0, 0, 1, 5'b01000, 1'b0};
    tbl[8]  = '{5'b11111,   50, 0, 0, 0, 0, 5'b00000, 1'b0};
    tbl[9]  = '{5'b11010,  600, 2, 0, 2, 0, 5'b00101, 1'b0};
    tbl[10] = '{5'b11111,   50, 0, 0, 0, 0, 5'b00000, 1'b0};
    repeat (3) step();
    check("reset_outputs", outs(), 0);
    clear = 1'b0;
    for (int v = 0; v < 11; v++) begin
      run(tbl[v].raw, tbl[v].ticks, cs, cm, ch, cc);
      check($sformatf("tbl%0d_sec", v), cs, tbl[v].n_sec);
      check($sformatf("tbl%0d_min", v), cm, tbl[v].n_min);
      check($sformatf("tbl%0d_hour", v), ch, tbl[v].n_hour);
      check($sformatf("tbl%0d_clr", v), cc, tbl[v].n_clr);
      check($sformatf("tbl%0d_level", v), int'(kif.key_level), int'(tbl[v].lvl));
      check($sformatf("tbl%0d_keep", v), int'(kif.keep), int'(tbl[v].keep));
    end
    kif.key_raw = 5'b11110;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (i == 21) check("sec_level_before", int'(kif.key_level[0]), 0);
      if (i == 22) check("sec_level_at22", int'(kif.key_level[0]), 1);
      if (i == 22) check("sec_pulse_at22", int'(kif.adjust_sec), 0);
      if (i == 23) check("sec_pulse_at23", int'(kif.adjust_sec), 1);
      if (i > 23) n += int'(kif.adjust_sec);
    end
    check("sec_no_early_repeat", n, 0);
    run(REL, 50, cs, cm, ch, cc);
    n = 0;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      kif.key_raw = (i < 100 && (i / 5) % 2 == 0) ? 5'b11011 : REL;
      step();
      n += int'(kif.adjust_hour);
      seen |= int'(kif.key_level[2]);
    end
    check("glitch_level", seen, 0);
    check("glitch_pulses", n, 0);
    kif.key_raw = 5'b11110;
    n = 0;
    for (int i = 0; i <= 830; i++) begin
      clear = (i == 300);
      step();
      n += int'(kif.adjust_sec);
      if (i == 23) check("rst_first_pulse", int'(kif.adjust_sec), 1);
      if (i == 300) check("rst_cleared", outs(), 0);
      if (i == 523) check("rst_cancelled_repeat", int'(kif.adjust_sec), 0);
      if (i == 324) check("rst_fresh_pulse", int'(kif.adjust_sec), 1);
      if (i == 824) check("rst_repeat_after", int'(kif.adjust_sec), 1);
    end
    clear = 1'b0;
    check("rst_pulse_count", n, 3);
    run(REL, 50, cs, cm, ch, cc);
    for (int r = 0; r < 60; r++) begin
      kif.key_raw = 5'($urandom);
      clear = ($urandom_range(0, 19) == 0);
      step();
      clear = 1'b0;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 700)) : int'($urandom_range(1, 30));
      repeat (hold) step();
    end
    run(REL, 50, cs, cm, ch, cc);
    check("final_level", int'(kif.key_level), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
